ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It sits directly downstream of the BCD/up-counter stage and consumes a 4-digit BCD value plus per-digit decimal points. It latches each new value into a shadow register only at a frame boundary, so a digit never tears mid-scan. It then scans the digits at a programmable rate with leading-zero blanking, driving `anode`/`cathode` directly.

## Interface

- `TICK_DIV`, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥ 2.
- `LZ_BLANK`, default 1: 1 = blank leading zeros in digits 3..1; 0 = show all digits.

- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `value`  in  16  four BCD nibbles; `value[3:0]` = digit 0 (rightmost).
- `dp`  in  4  decimal point request per digit; `dp[i]` = digit i.
- `load`  in  1  one-cycle strobe that captures `value` and `dp`.
- `cathode`  out  8  `{dp,g,f,e,d,c,b,a}`, active-low, registered.
- `anode`  out  4  digit enable, active-low, registered; `anode[0]` = digit 0.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation

**Reset** (`rst` low, asynchronous): all internal state clears.
- prescaler = 0, index = 0.
- shadow = 0, pending = 0, pending flag = 0.
- `anode` = 4'hF, `cathode` = 8'hFF, `frame_done` = 0.

**Prescaler**
- Counts 0..TICK_DIV-1 and wraps.
- `tick` is asserted when the count equals TICK_DIV-1.

**Digit index**
- Advances on `tick` in the order 0→1→2→3→0.
- The edge with `tick` and index == 3 is the **frame boundary**.

**Load path**
- `load` high: `value`/`dp` go into pending and the pending flag sets.
- A repeat `load` before the boundary overwrites pending (last write wins).
- At the frame boundary:
  - if `load` is high on that same cycle, shadow takes `value`/`dp` directly (bypass);
  - else if the pending flag is set, shadow takes pending;
  - in both cases the pending flag clears.
- With no pending data, shadow holds its value.

**Decode** (per displayed nibble): 0–9 → 8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90. Nibbles A–F → dash, 8'hBF.

**Leading-zero blanking** (`LZ_BLANK` = 1):
- Digit i (i ≥ 1) is blanked when its nibble and every higher nibble are 0.
- Blanked segments g..a read 7'h7F.
- Digit 0 is never blanked.

**Decimal point**: `cathode[7]` = ~dp[i], applied even on a blanked digit.

**Anode**: exactly one bit is low at a time, after reset release.

## Timing

- Outputs are registered from the index and shadow state: `anode`/`cathode` lag the index by 1 cycle.
- First edge after reset release: `anode` = 4'hE, `cathode` = 8'hC0.
- `frame_done` is high for exactly 1 cycle, the cycle after the boundary edge. It has the same timing as the anode switching to digit 0 with the new shadow.
- Load-to-display latency: ≤ 4·TICK_DIV + 1 cycles. A `load` on the boundary cycle appears 1 cycle later.
- Each digit is held for exactly TICK_DIV cycles; a full frame is 4·TICK_DIV cycles.
- Reset mid-frame: outputs go to their reset values immediately (asynchronously). Any pending load is discarded, and the display restarts at digit 0 showing "0".

## Structure

- Package `ssd_pkg` holds:
  - segment constants `SEG_0`..`SEG_9`, `SEG_DASH` (8'hBF), `SEG_BLANK` (8'hFF);
  - `ANODE_OFF` (4'hF).
- Sub-module `bcd_to_seg`: combinational nibble → 7-segment active-low decoder, instantiated once on the muxed nibble.
- Prescaler, index, load/shadow logic and blanking stay in `ssd_scan_driver`.

## Test plan

All scenarios run with TICK_DIV = 4.

1. **Reset:** hold `rst` low.
   - Required: `anode` = F, `cathode` = FF, `frame_done` = 0.
   - On release: `anode` = E, `cathode` = C0, and each digit is held 4 cycles.
2. **Basic load:** `load` `value` = 16'h1234, `dp` = 0.
   - Required, from the frame after the next boundary: E/99, D/B0, B/A4, 7/F9.
   - `frame_done` pulses once per 16 cycles.
3. **Leading-zero blanking:** `value` = 16'h0050.
   - Required: digits 3 and 2 = FF, digit 1 = 92, digit 0 = C0.
   - With `LZ_BLANK` = 0: digits 3 and 2 = C0.
4. **Load timing:** load 16'h1111, then 16'h2222, both before the boundary.
   - Required: only 2222 is displayed.
   - A `load` of 16'h3333 asserted on the boundary cycle is shown in the very next frame.
5. **Dash and decimal point:** `value` = 16'hA200 with `dp` = 4'b0100.
   - Required: digit 3 = BF, digit 2 = 24, digits 1 and 0 = C0.
6. **Reset mid-frame:** assert `rst` while digit 2 is displayed with a load pending.
   - Required: immediate F/FF.
   - After release, the display shows 0000 with only digit 0 lit as C0, and the pending value never appears.

Source files
------------

// File: rtl/ssd_scan_driver_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan driver.
//   SEG_*     : active-low cathode patterns {dp,g,f,e,d,c,b,a} with dp off.
//   ANODE_OFF : all digit enables released (active-low).
//   anode_for : active-low one-hot digit enable for a digit index.
package ssd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low enable for the selected digit; every other digit stays dark.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = ANODE_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to active-low segments g..a.
//   nibble in  4 : BCD digit; codes A..F are shown as a dash.
//   seg    out 7 : {g,f,e,d,c,b,a}, active-low.
module bcd_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Segment lookup; anything that is not a decimal digit renders as a dash.
  always_comb begin
    seg = SEG_DASH[6:0];
    case (nibble)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display with frame-synchronous value update.
//   clk        in  1  : system clock.
//   rst        in  1  : asynchronous active-low reset.
//   value      in  16 : four BCD nibbles, value[3:0] is digit 0 (rightmost).
//   dp         in  4  : decimal point request, dp[i] belongs to digit i.
//   load       in  1  : strobe capturing value/dp.
//   cathode    out 8  : {dp,g,f,e,d,c,b,a}, active-low, registered.
//   anode      out 4  : digit enables, active-low, registered.
//   frame_done out 1  : one-cycle pulse when digit 0 of a new frame appears.
// Parameters: TICK_DIV cycles per digit slot (>= 2); LZ_BLANK enables
// leading-zero blanking on digits 3..1.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [7:0]  cathode,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [15:0]   shadow_val_r;
  logic [3:0]    shadow_dp_r;
  logic [15:0]   pend_val_r;
  logic [3:0]    pend_dp_r;
  logic          pend_flag_r;
  logic          bnd_d_r;
  logic [7:0]    cathode_r;
  logic [3:0]    anode_r;
  logic          frame_done_r;

  logic          tick_s;
  logic          boundary_s;
  logic [3:0]    nibble_s;
  logic          dp_bit_s;
  logic          zero_above_s;
  logic [6:0]    seg_s;
  logic [6:0]    seg_mux_s;

  assign tick_s     = (presc_r == PRESC_MAX);
  assign boundary_s = tick_s && (idx_r == 2'd3);

  // Digit-slot prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Digit index 0->1->2->3->0, one step per slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= 2'd0;
    end else if (tick_s) begin
      idx_r <= idx_r + 2'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Pending buffer: last load wins; drained (flag cleared) at every frame boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val_r  <= 16'h0000;
      pend_dp_r   <= 4'h0;
      pend_flag_r <= 1'b0;
    end else if (boundary_s) begin
      pend_flag_r <= 1'b0;
    end else if (load) begin
      pend_val_r  <= value;
      pend_dp_r   <= dp;
      pend_flag_r <= 1'b1;
    end else begin
      pend_flag_r <= pend_flag_r;
    end
  end

  // Shadow register only changes at the frame boundary, so a scan never tears.
  // A load coinciding with the boundary bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_val_r <= 16'h0000;
      shadow_dp_r  <= 4'h0;
    end else if (boundary_s && load) begin
      shadow_val_r <= value;
      shadow_dp_r  <= dp;
    end else if (boundary_s && pend_flag_r) begin
      shadow_val_r <= pend_val_r;
      shadow_dp_r  <= pend_dp_r;
    end else begin
      shadow_val_r <= shadow_val_r;
      shadow_dp_r  <= shadow_dp_r;
    end
  end

  // Select the nibble/dp for the current digit and whether every nibble from
  // this digit upward is zero (digit 0 is never a leading zero).
  always_comb begin
    nibble_s     = shadow_val_r[3:0];
    dp_bit_s     = shadow_dp_r[0];
    zero_above_s = 1'b0;
    case (idx_r)
      2'd0: begin
        nibble_s     = shadow_val_r[3:0];
        dp_bit_s     = shadow_dp_r[0];
        zero_above_s = 1'b0;
      end
      2'd1: begin
        nibble_s     = shadow_val_r[7:4];
        dp_bit_s     = shadow_dp_r[1];
        zero_above_s = (shadow_val_r[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s     = shadow_val_r[11:8];
        dp_bit_s     = shadow_dp_r[2];
        zero_above_s = (shadow_val_r[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s     = shadow_val_r[15:12];
        dp_bit_s     = shadow_dp_r[3];
        zero_above_s = (shadow_val_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s     = shadow_val_r[3:0];
        dp_bit_s     = shadow_dp_r[0];
        zero_above_s = 1'b0;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .nibble (nibble_s),
    .seg    (seg_s)
  );

  // Leading-zero blanking darkens g..a only; the decimal point is kept.
  always_comb begin
    seg_mux_s = seg_s;
    if (LZ_BLANK && zero_above_s) begin
      seg_mux_s = SEG_BLANK[6:0];
    end else begin
      seg_mux_s = seg_s;
    end
  end

  // Output stage: one cycle behind the index/shadow; frame_done is delayed
  // twice so it coincides with the first cycle of digit 0 in the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_r      <= ANODE_OFF;
      cathode_r    <= SEG_BLANK;
      bnd_d_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      anode_r      <= anode_for(idx_r);
      cathode_r    <= {~dp_bit_s, seg_mux_s};
      bnd_d_r      <= boundary_s;
      frame_done_r <= bnd_d_r;
    end
  end

  assign anode      = anode_r;
  assign cathode    = cathode_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (TICK_DIV = 4). Two instances share the
// stimulus: one with leading-zero blanking, one without. Each expected frame
// (four cathode bytes per instance plus the frame_done flag on its first
// cycle) is queued when the stimulus is issued; the monitor pops one entry
// whenever a DUT frame starts (anode goes to E) and checks all 16 cycles.
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [7:0]  cathode, cathode_nb;
  logic [3:0]  anode, anode_nb;
  logic        frame_done, frame_done_nb;

  typedef struct packed {
    logic [31:0] lz;  // digit3..digit0 cathodes, blanking instance
    logic [31:0] nb;  // digit3..digit0 cathodes, no-blanking instance
    logic        fd;  // frame_done expected on first cycle of the frame
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  int   e_cnt;

  ssd_scan_driver #(.TICK_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .cathode(cathode), .anode(anode), .frame_done(frame_done)
  );

  ssd_scan_driver #(.TICK_DIV(4), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .cathode(cathode_nb), .anode(anode_nb), .frame_done(frame_done_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      e_cnt++;
    end
    #1;
  endtask

  task automatic go_to(input int k);
    if (k > e_cnt) adv(k - e_cnt);
  endtask

  // Present value/dp with load so that it is sampled on edge k.
  task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] d);
    go_to(k - 1);
    value = v;
    dp    = d;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    dp    = 4'h0;
  endtask

  task automatic push(input logic [31:0] lz, input logic [31:0] nb, input logic fd);
    exp_t e;
    e.lz = lz;
    e.nb = nb;
    e.fd = fd;
    q.push_back(e);
  endtask

  // Monitor: reset values while rst is low; otherwise frame-by-frame checking.
  initial begin
    exp_t       cur;
    logic       in_frame;
    int         cyc;
    int         slot;
    logic [3:0] prev_anode;
    logic [3:0] exp_an;
    in_frame   = 1'b0;
    cyc        = 0;
    prev_anode = 4'hF;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_anode", {4'h0, anode}, 8'h0F);
        chk("rst_cathode", cathode, 8'hFF);
        chk("rst_frame_done", {7'h00, frame_done}, 8'h00);
        chk("rst_cathode_nb", cathode_nb, 8'hFF);
        in_frame   = 1'b0;
        prev_anode = anode;
      end else begin
        if (anode == 4'hE && prev_anode != 4'hE) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            in_frame = 1'b0;
            $display("FAIL frame_start actual=unexpected_frame required=none at %0t", $time);
          end else begin
            cur      = q.pop_front();
            in_frame = 1'b1;
            cyc      = 0;
          end
        end
        if (in_frame) begin
          slot   = cyc / 4;
          exp_an = ~(4'b0001 << slot);
          chk("anode", {4'h0, anode}, {4'h0, exp_an});
          chk("anode_nb", {4'h0, anode_nb}, {4'h0, exp_an});
          chk("cathode", cathode, cur.lz[8*slot +: 8]);
          chk("cathode_nb", cathode_nb, cur.nb[8*slot +: 8]);
          chk("frame_done", {7'h00, frame_done}, {7'h00, (cyc == 0) ? cur.fd : 1'b0});
          chk("frame_done_nb", {7'h00, frame_done_nb}, {7'h00, (cyc == 0) ? cur.fd : 1'b0});
          cyc++;
          if (cyc == 16) in_frame = 1'b0;
        end else begin
          checks++;
          errors++;
          $display("FAIL frame_align actual_anode=%h required=E_at_frame_start at %0t", anode, $time);
        end
        prev_anode = anode;
      end
    end
  end

  // Stimulus. Edge k = k-th rising edge after reset release; frame m shows the
  // shadow latched on boundary edge 16m and is visible on edges 16m+1..16m+16.
  initial begin
    checks = 0;
    errors = 0;
    e_cnt  = 0;
    value  = 16'h0000;
    dp     = 4'h0;
    load   = 1'b0;
    rst    = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Frame 0 after release: shadow 0000, digits 3..1 blanked.
    push(32'hFFFF_FFC0, 32'hC0C0_C0C0, 1'b0);
    #2 rst = 1'b1;
    e_cnt = 0;

    // Basic load 1234 -> frames 1 and 2.
    do_load(5, 16'h1234, 4'h0);
    push(32'hF9A4_B099, 32'hF9A4_B099, 1'b1);
    push(32'hF9A4_B099, 32'hF9A4_B099, 1'b1);

    // Leading zeros 0050 -> frame 3.
    do_load(40, 16'h0050, 4'h0);
    push(32'hFFFF_92C0, 32'hC0C0_92C0, 1'b1);

    // Two loads before boundary 64: only 2222 shows in frame 4.
    do_load(53, 16'h1111, 4'h0);
    do_load(58, 16'h2222, 4'h0);
    push(32'hA4A4_A4A4, 32'hA4A4_A4A4, 1'b1);

    // Pending 1111, then 3333 on boundary edge 80: 3333 bypasses into frame 5,
    // and the cleared pending value must not surface in frame 6.
    do_load(70, 16'h1111, 4'h0);
    do_load(80, 16'h3333, 4'h0);
    push(32'hB0B0_B0B0, 32'hB0B0_B0B0, 1'b1);
    push(32'hB0B0_B0B0, 32'hB0B0_B0B0, 1'b1);

    // Dash and decimal point on digit 2 -> frame 7.
    do_load(100, 16'hA200, 4'b0100);
    push(32'hBF24_C0C0, 32'hBF24_C0C0, 1'b1);

    // Decimal point on a blanked digit 3 -> frames 8 and 9.
    do_load(120, 16'h0000, 4'b1000);
    push(32'h7FFF_FFC0, 32'h40C0_C0C0, 1'b1);
    push(32'h7FFF_FFC0, 32'h40C0_C0C0, 1'b1);

    // Pending load in frame 9, reset while digit 2 is lit (edges 153..156),
    // asserted just after a rising edge so only an asynchronous clear shows.
    do_load(150, 16'h5678, 4'h0);
    go_to(154);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push(32'hFFFF_FFC0, 32'hC0C0_C0C0, 1'b0);
    push(32'hFFFF_FFC0, 32'hC0C0_C0C0, 1'b1);
    #2 rst = 1'b1;
    e_cnt = 0;
    go_to(33);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL frames_consumed actual_left=%0d required_left=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
